fc_argmax: RTL and testbench
============================

# fc_argmax

Classification stage directly downstream of the fully-connected layer. It accepts the FC layer's output nodes as a stream of signed 16-bit words, one per handshake, and tracks the running maximum. After the last node it reports the index of the largest node as the predicted class, with a one-cycle done pulse. It is the final stage of the accelerator datapath and drives the result register seen by the host.

## Interface
- `NUM_CLASSES`, default 10: number of FC output nodes per inference; legal range 2..1024.
- `DATA_WIDTH`, default 16: node word width; two's-complement signed (8.8 fixed point, matching the FC output).
- `IDX_W`, default `$clog2(NUM_CLASSES)`: width of the class index.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: begin a new inference; sampled only in IDLE.
- `in_valid`, input, 1: `in_data` is valid.
- `in_data`, input, `DATA_WIDTH`: FC output node value, in node order 0..`NUM_CLASSES`-1.
- `in_ready`, output, 1: block accepts `in_data` this cycle.
- `busy`, output, 1: high while in ACCEPT.
- `done`, output, 1: one-cycle pulse; `class_idx` is valid.
- `class_idx`, output, `IDX_W`: index of the maximum node. Held until the next `done`.
- `max_score`, output, `DATA_WIDTH`: value of the maximum node. Present only with `FC_ARGMAX_SCORE_EN`.

## Operation
- **States:** IDLE, ACCEPT, REPORT.
- **IDLE:**
  - `in_ready`=0.
  - `start`=1 moves to ACCEPT and clears `cnt` to 0.
  - The `best_val` and `best_idx` working registers are not touched in IDLE.
- **ACCEPT:**
  - `in_ready`=1 and `busy`=1.
  - A beat transfers when `in_valid && in_ready`.
  - On a beat with `cnt==0`: `best_val` ← `in_data`, `best_idx` ← 0.
  - On a beat with `cnt>0`: if `$signed(in_data) > $signed(best_val)` (strictly greater), `best_val` ← `in_data` and `best_idx` ← `cnt`.
  - Ties keep the lower index.
  - `cnt` increments on every beat.
  - The beat with `cnt==NUM_CLASSES-1` moves to REPORT.
  - The comparison on that final beat is included in the result.
- **REPORT:**
  - `class_idx` ← `best_idx`, `max_score` ← `best_val`.
  - `done`=1 for this single cycle.
  - Next state is IDLE unconditionally.
- **Comparison:** full-width signed. No saturation or rounding. 0x8000 is the smallest value; 0x7FFF is the largest.
- **Back-pressure:** `in_valid` low in ACCEPT stalls the block with no timeout; `cnt` and the best registers hold.
- **`start` outside IDLE** (ACCEPT or REPORT) is ignored; it does not restart the count.
- **`start` held high continuously:** back-to-back inferences run, with one IDLE cycle between REPORT and the next ACCEPT.
- **Reset** (any time, including mid-ACCEPT):
  - State → IDLE; `cnt`, `best_val`, `best_idx` → 0.
  - `done`, `busy`, `in_ready`, `class_idx`, `max_score` → 0.
  - A partially accepted vector is discarded; no `done` is produced for it.

## Timing
- All outputs are registered except `in_ready` and `busy`, which decode the current state.
- `start` at edge *t* gives `in_ready`=1 in cycle *t*+1.
- Final beat accepted at edge *e* gives REPORT in cycle *e*+1: `done`=1 and `class_idx` valid from that cycle. Back in IDLE at *e*+2.
- Minimum inference with `in_valid` held high: 1 (start) + `NUM_CLASSES` (beats) + 1 (REPORT) cycles.
- Throughput is one node per cycle.
- `class_idx` changes only in the cycle `done` is asserted.

## Configuration
- **`FC_ARGMAX_SCORE_EN` defined:**
  - `max_score` port and register exist.
  - The register is loaded in REPORT and held like `class_idx`; its reset value is 0.
- **`FC_ARGMAX_SCORE_EN` undefined:**
  - The `max_score` port is absent.
  - `best_val` remains internal (still required for comparison).
  - Behaviour is otherwise identical.

## Test plan
- **Basic winner:** `NUM_CLASSES`=10, stream 0x0100,0x0200,0xFF00,0x0500,0x0080,0x0000,0x0300,0x0400,0x0010,0x0001 with `in_valid` held high → `done` one cycle after the last beat, `class_idx`=3, `max_score`=0x0500; back in IDLE the next cycle.
- **All negative and tie:** stream 0xFF00 ×10 → `class_idx`=0. Stream 0x8000 ×9 then 0xFFFF at node 9 → `class_idx`=9, `max_score`=0xFFFF.
- **Back-pressure:** random `in_valid` gaps of 0–5 cycles, max 0x7FFF at node 6 → `class_idx`=6; `done` exactly one cycle after the 10th transferred beat; no beats counted while `in_valid`=0.
- **Reset mid-vector:** assert `rst` after 4 beats → all outputs 0 immediately. Then a new full vector with max at node 2 → `class_idx`=2, only one `done`.
- **Start during ACCEPT and back-to-back:** pulse `start` again at beat 5 → ignored, and `done` still comes after 10 beats. With `start` held high for two vectors → two `done` pulses separated by 12 cycles, each with the correct index.

Source files
------------

// File: rtl/fc_argmax.sv
// Argmax over a stream of signed FC-layer outputs; reports the winning class index with a done pulse.
// Optional feature: define FC_ARGMAX_SCORE_EN to expose the winning value on max_score.
module fc_argmax #(
    parameter int NUM_CLASSES = 10,
    parameter int DATA_WIDTH  = 16,
    parameter int IDX_W       = $clog2(NUM_CLASSES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  busy,
    output logic                  done,
    output logic [IDX_W-1:0]      class_idx
`ifdef FC_ARGMAX_SCORE_EN
    ,
    output logic [DATA_WIDTH-1:0] max_score
`endif
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCEPT = 2'd1;
    localparam logic [1:0] S_REPORT = 2'd2;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic [IDX_W-1:0]      cnt;
    logic [IDX_W-1:0]      best_idx;
    logic [IDX_W-1:0]      upd_idx;
    logic [DATA_WIDTH-1:0] best_val;
    logic [DATA_WIDTH-1:0] upd_val;
    logic                  beat;
    logic                  last_beat;

    assign in_ready  = (state == S_ACCEPT);
    assign busy      = (state == S_ACCEPT);
    assign beat      = in_valid && in_ready;
    assign last_beat = beat && (cnt == LAST_IDX);

    // Running best including the current beat; strict compare keeps the lower index on ties.
    always_comb begin
        upd_idx = best_idx;
        upd_val = best_val;
        if (cnt == '0) begin
            upd_idx = '0;
            upd_val = in_data;
        end else if ($signed(in_data) > $signed(best_val)) begin
            upd_idx = cnt;
            upd_val = in_data;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_ACCEPT;
            S_ACCEPT: if (last_beat) state_nxt = S_REPORT;
            S_REPORT: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Result registers load on the final beat so they are already valid during the REPORT cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            best_idx  <= '0;
            best_val  <= '0;
            done      <= 1'b0;
            class_idx <= '0;
`ifdef FC_ARGMAX_SCORE_EN
            max_score <= '0;
`endif
        end else begin
            state <= state_nxt;
            done  <= last_beat;
            if (state == S_IDLE && start) begin
                cnt <= '0;
            end else if (beat) begin
                cnt      <= last_beat ? '0 : cnt + IDX_W'(1);
                best_idx <= upd_idx;
                best_val <= upd_val;
            end
            if (last_beat) begin
                class_idx <= upd_idx;
`ifdef FC_ARGMAX_SCORE_EN
                max_score <= upd_val;
`endif
            end
        end
    end

endmodule

// File: tb/tb_fc_argmax.sv
// Directed self-checking bench for fc_argmax (NUM_CLASSES=10, 16-bit data).
module tb_fc_argmax;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_ready;
    logic        busy;
    logic        done;
    logic [3:0]  class_idx;
`ifdef FC_ARGMAX_SCORE_EN
    logic [15:0] max_score;
`endif

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          early = 0;
    int          t1 = 0;
    int          d0 = 0;
    logic [15:0] vec [10];

    fc_argmax #(.NUM_CLASSES(10), .DATA_WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .busy      (busy),
        .done      (done),
        .class_idx (class_idx)
`ifdef FC_ARGMAX_SCORE_EN
        ,
        .max_score (max_score)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Feeds vec[0..9]; optional random idle gaps and a start pulse on beat start_at.
    task automatic feed(input int maxgap, input int start_at);
        early = 0;
        for (int i = 0; i < 10; i++) begin
            if (maxgap > 0) begin
                int gap;
                gap = $urandom_range(maxgap, 0);
                for (int g = 0; g < gap; g++) begin
                    in_valid = 1'b0;
                    step();
                    if (done) early++;
                end
            end
            in_valid = 1'b1;
            in_data  = vec[i];
            if (i == start_at) begin
                start = 1'b1;
                step();
                start = 1'b0;
            end else begin
                step();
            end
            if (i < 9 && done) early++;
        end
        in_valid = 1'b0;
    endtask

    task automatic load(input logic [15:0] a0, a1, a2, a3, a4, a5, a6, a7, a8, a9);
        vec[0] = a0; vec[1] = a1; vec[2] = a2; vec[3] = a3; vec[4] = a4;
        vec[5] = a5; vec[6] = a6; vec[7] = a7; vec[8] = a8; vec[9] = a9;
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", in_ready, 0);
        check("rst_idx", class_idx, 0);
        step();
        rst = 1'b0;
        step();
        check("idle_ready", in_ready, 0);

        // Basic winner
        load(16'h0100, 16'h0200, 16'hFF00, 16'h0500, 16'h0080,
             16'h0000, 16'h0300, 16'h0400, 16'h0010, 16'h0001);
        start = 1'b1;
        step();
        start = 1'b0;
        check("basic_ready", in_ready, 1);
        check("basic_busy", busy, 1);
        feed(0, -1);
        check("basic_early", early, 0);
        check("basic_done", done, 1);
        check("basic_idx", class_idx, 3);
        check("basic_report_ready", in_ready, 0);
`ifdef FC_ARGMAX_SCORE_EN
        check("basic_score", max_score, 16'h0500);
`endif
        step();
        check("basic_done_low", done, 0);
        check("basic_idle_ready", in_ready, 0);
        check("basic_idx_hold", class_idx, 3);

        // All-equal negatives: tie keeps node 0
        load(16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00,
             16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00);
        start = 1'b1; step(); start = 1'b0;
        feed(0, -1);
        check("tie_done", done, 1);
        check("tie_idx", class_idx, 0);
`ifdef FC_ARGMAX_SCORE_EN
        check("tie_score", max_score, 16'hFF00);
`endif
        step();

        // Most-negative values, winner at last node
        load(16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000,
             16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'hFFFF);
        start = 1'b1; step(); start = 1'b0;
        feed(0, -1);
        check("neg_done", done, 1);
        check("neg_idx", class_idx, 9);
`ifdef FC_ARGMAX_SCORE_EN
        check("neg_score", max_score, 16'hFFFF);
`endif
        step();

        // Back-pressure: 0x7FFF at node 6, tie at node 7 must not win
        load(16'h0100, 16'h8000, 16'h7FFE, 16'h0000, 16'hFFFF,
             16'h1234, 16'h7FFF, 16'h7FFF, 16'h0001, 16'h7FFE);
        start = 1'b1; step(); start = 1'b0;
        feed(5, -1);
        check("bp_early", early, 0);
        check("bp_done", done, 1);
        check("bp_idx", class_idx, 6);
`ifdef FC_ARGMAX_SCORE_EN
        check("bp_score", max_score, 16'h7FFF);
`endif
        step();
        check("bp_done_low", done, 0);

        // Reset mid-vector
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 16'h0700;
            step();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("mid_rst_idx", class_idx, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", in_ready, 0);
        check("mid_rst_done", done, 0);
        step();
        rst = 1'b0;
        step();
        d0 = done_cnt;
        load(16'h0010, 16'h0020, 16'h0300, 16'h0100, 16'hFFF0,
             16'h0200, 16'h02FF, 16'h0000, 16'h8000, 16'h0300);
        start = 1'b1; step(); start = 1'b0;
        feed(0, -1);
        check("post_rst_done", done, 1);
        check("post_rst_idx", class_idx, 2);
        step();
        step();
        check("post_rst_one_done", done_cnt - d0, 1);

        // Start pulse during ACCEPT is ignored
        load(16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005,
             16'h0006, 16'h0050, 16'h0007, 16'h0008, 16'h0009);
        start = 1'b1; step(); start = 1'b0;
        feed(0, 5);
        check("restart_early", early, 0);
        check("restart_done", done, 1);
        check("restart_idx", class_idx, 6);
        step();

        // Back-to-back with start held high
        load(16'h0001, 16'h0400, 16'h0002, 16'h0003, 16'h0004,
             16'h0005, 16'h0006, 16'h0007, 16'h0008, 16'h0009);
        start = 1'b1;
        step();
        feed(0, -1);
        check("b2b_a_done", done, 1);
        check("b2b_a_idx", class_idx, 1);
        t1 = cyc;
        load(16'h8000, 16'h0001, 16'h0002, 16'h0003, 16'h0004,
             16'h0005, 16'h0006, 16'h0007, 16'h7000, 16'h0009);
        step();
        check("b2b_idle", in_ready, 0);
        step();
        check("b2b_accept", in_ready, 1);
        feed(0, -1);
        start = 1'b0;
        check("b2b_b_done", done, 1);
        check("b2b_b_idx", class_idx, 8);
        check("b2b_spacing", cyc - t1, 12);
        step();
        check("b2b_final_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
